// File: rtl/memory_unit_if.sv
// Bus-side interface of the memory unit: the shared-bus MAR/RAM path and
// the program-load handshake. The master drives controls and program bytes;
// the slave (memory_unit) returns the bus drive value and status.
interface memory_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] bus_in;
    logic              mem_load;
    logic              mem_en;
    logic [DATA_W-1:0] out;
    logic [ADDR_W-1:0] mar;
    logic              prog_mode;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ready;
    logic [ADDR_W:0]   prog_count;

    modport master (
        output bus_in, mem_load, mem_en, prog_mode, prog_valid, prog_data,
        input  out, mar, prog_ready, prog_count
    );

    modport slave (
        input  bus_in, mem_load, mem_en, prog_mode, prog_valid, prog_data,
        output out, mar, prog_ready, prog_count
    );
endinterface

// File: rtl/memory_unit.sv
// Memory unit: RAM addressed through a MAR loaded from the shared bus,
// with zero-latency read onto the bus, plus a program-load mode (PROG) in
// which bytes are streamed into RAM through a valid/ready handshake.
// The RAM has no reset so its contents survive a reset.
// The instance parameters must match those of the connected interface.
module memory_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    memory_unit_if.slave  mem_if
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_W:0]   COUNT_ONE = 1;
    // Saturation value of prog_count: exactly 2**ADDR_W bytes.
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PROG = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] mar_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W:0]   prog_count_reg;
    logic              prog_ready_reg;

    logic [DATA_W-1:0] ram [DEPTH];

    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;

    // A byte is accepted only while ready is shown and reset is not active,
    // so a write presented on a reset edge is dropped.
    assign wr_en = rst && (state_reg == ST_PROG) && prog_ready_reg && mem_if.prog_valid;

    // Bus drive is only permitted in RUN; PROG forces the bus quiet.
    assign rd_en   = mem_if.mem_en && (state_reg == ST_RUN);
    assign rd_data = ram[mar_reg];

    // RAM write port: the program handshake is the only writer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_ptr_reg] <= mem_if.prog_data;
        end
    end

    // Mode FSM with MAR, write pointer, byte counter and ready flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_RUN;
            mar_reg        <= '0;
            wr_ptr_reg     <= '0;
            prog_count_reg <= '0;
            prog_ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (mem_if.mem_load) begin
                        mar_reg <= mem_if.bus_in[ADDR_W-1:0];
                    end
                    if (mem_if.prog_mode) begin
                        state_reg      <= ST_PROG;
                        wr_ptr_reg     <= '0;
                        prog_count_reg <= '0;
                        prog_ready_reg <= 1'b1;
                    end
                end
                ST_PROG: begin
                    // Accept the byte even on the leaving edge: ready was high.
                    if (wr_en) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                        if (prog_count_reg != COUNT_MAX) begin
                            prog_count_reg <= prog_count_reg + COUNT_ONE;
                        end
                    end
                    if (!mem_if.prog_mode) begin
                        state_reg      <= ST_RUN;
                        prog_ready_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= ST_RUN;
                    prog_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Per-bit gating of the read word onto the bus drive.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_out_gate
            assign mem_if.out[gi] = rd_data[gi] & rd_en;
        end
    endgenerate

    assign mem_if.mar        = mar_reg;
    assign mem_if.prog_ready = prog_ready_reg;
    assign mem_if.prog_count = prog_count_reg;
endmodule

// File: tb/tb_memory_unit.sv
// Testbench for memory_unit: directed scenarios followed by randomized
// traffic, all compared against a transaction-level reference model.
module tb_memory_unit;
    logic clk;
    logic rst;

    memory_unit_if #(.ADDR_W(4), .DATA_W(8)) bus_if ();

    memory_unit #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    logic [7:0] m_ram [16];
    int         m_mar  = 0;
    bit         m_prog = 1'b0;
    int         m_cnt  = 0;
    int         m_ptr  = 0;

    logic [7:0] out_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input bit r, input bit pm, input bit pv, input logic [7:0] pd,
                         input bit ml, input bit me, input logic [7:0] bi);
        rst               = r;
        bus_if.prog_mode  = pm;
        bus_if.prog_valid = pv;
        bus_if.prog_data  = pd;
        bus_if.mem_load   = ml;
        bus_if.mem_en     = me;
        bus_if.bus_in     = bi;
    endtask

    // One clock: check the combinational bus drive before the edge, advance
    // the model by the rules of the unit, then check registered outputs.
    task automatic cycle(input string tag);
        logic [7:0] exp_out;
        #1;
        exp_out  = (!m_prog && bus_if.mem_en) ? m_ram[m_mar] : 8'h00;
        out_seen = bus_if.out;
        check({tag, ":out"}, {24'h0, out_seen}, {24'h0, exp_out});
        @(posedge clk);
        if (!rst) begin
            m_prog = 1'b0;
            m_mar  = 0;
            m_cnt  = 0;
            m_ptr  = 0;
        end else if (m_prog) begin
            if (bus_if.prog_valid) begin
                m_ram[m_ptr] = bus_if.prog_data;
                m_ptr = (m_ptr + 1) % 16;
                if (m_cnt < 16) m_cnt = m_cnt + 1;
            end
            m_prog = bus_if.prog_mode;
        end else begin
            if (bus_if.mem_load) m_mar = bus_if.bus_in % 16;
            if (bus_if.prog_mode) begin
                m_prog = 1'b1;
                m_cnt  = 0;
                m_ptr  = 0;
            end
        end
        #1;
        check({tag, ":mar"},   {28'h0, bus_if.mar},        m_mar);
        check({tag, ":ready"}, {31'h0, bus_if.prog_ready}, {31'h0, m_prog});
        check({tag, ":count"}, {27'h0, bus_if.prog_count}, m_cnt);
    endtask

    // Point MAR at addr, then return the word seen with mem_en high.
    task automatic read_at(input int addr, input string tag);
        drive(1, 0, 0, 8'h00, 1, 0, 8'(addr));
        cycle({tag, ":load"});
        drive(1, 0, 0, 8'h00, 0, 1, 8'h00);
        cycle({tag, ":rd"});
    endtask

    initial begin
        drive(0, 0, 0, 8'h00, 0, 0, 8'h00);
        cycle("reset");
        check("reset_mar",   {28'h0, bus_if.mar}, 0);
        check("reset_ready", {31'h0, bus_if.prog_ready}, 0);
        check("reset_count", {27'h0, bus_if.prog_count}, 0);

        // Three back-to-back program bytes
        drive(1, 1, 0, 8'h00, 0, 0, 8'h00);
        cycle("p3_enter");
        check("p3_ready_up", {31'h0, bus_if.prog_ready}, 1);
        drive(1, 1, 1, 8'h09, 0, 0, 8'h00); cycle("p3_b0");
        drive(1, 1, 1, 8'h1A, 0, 0, 8'h00); cycle("p3_b1");
        drive(1, 1, 1, 8'h2F, 0, 0, 8'h00); cycle("p3_b2");
        check("p3_count", {27'h0, bus_if.prog_count}, 3);
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00); cycle("p3_exit");
        check("p3_ready_down", {31'h0, bus_if.prog_ready}, 0);

        // MAR load ignores upper bus bits; read and bus release
        drive(1, 0, 0, 8'h00, 1, 0, 8'hF2); cycle("mar_load");
        check("mar_is_2", {28'h0, bus_if.mar}, 2);
        drive(1, 0, 0, 8'h00, 0, 1, 8'h00); cycle("rd2");
        check("rd2_val", {24'h0, out_seen}, 32'h2F);
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00); cycle("rd2_off");
        check("rd2_off_val", {24'h0, out_seen}, 0);
        read_at(0, "rd0"); check("rd0_val", {24'h0, out_seen}, 32'h09);
        read_at(1, "rd1"); check("rd1_val", {24'h0, out_seen}, 32'h1A);

        // Seventeen bytes: counter saturates, pointer wraps
        drive(1, 1, 0, 8'h00, 0, 0, 8'h00); cycle("p17_enter");
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 1, 8'(i), 0, 0, 8'h00);
            cycle("p17_byte");
        end
        check("p17_count_sat", {27'h0, bus_if.prog_count}, 16);
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00); cycle("p17_exit");
        for (int a = 0; a < 16; a++) begin
            read_at(a, "p17_rd");
            check("p17_rd_val", {24'h0, out_seen}, (a == 0) ? 32'h10 : 32'(a));
        end

        // Valid while not ready is ignored
        drive(1, 0, 1, 8'h55, 0, 0, 8'h00); cycle("ign_run");
        check("ign_run_count", {27'h0, bus_if.prog_count}, 16);
        drive(1, 1, 1, 8'h66, 0, 0, 8'h00); cycle("ign_first");
        check("ign_first_count", {27'h0, bus_if.prog_count}, 0);
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00); cycle("ign_exit");
        read_at(0, "ign_rd0"); check("ign_rd0_val", {24'h0, out_seen}, 32'h10);

        // PROG ignores mem_load/mem_en; reset mid-PROG drops the write
        drive(1, 1, 0, 8'h00, 0, 0, 8'h00); cycle("rp_enter");
        drive(1, 1, 0, 8'h00, 1, 1, 8'h07); cycle("rp_ignore_bus");
        check("rp_out_quiet", {24'h0, out_seen}, 0);
        check("rp_mar_held", {28'h0, bus_if.mar}, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 8'hA0 + 8'(i), 0, 0, 8'h00);
            cycle("rp_byte");
        end
        drive(0, 1, 1, 8'hAA, 1, 0, 8'h0C); cycle("rp_reset");
        check("rp_ready", {31'h0, bus_if.prog_ready}, 0);
        check("rp_mar",   {28'h0, bus_if.mar}, 0);
        check("rp_count", {27'h0, bus_if.prog_count}, 0);
        read_at(4, "rp_rd4"); check("rp_rd4_val", {24'h0, out_seen}, 32'h04);
        read_at(3, "rp_rd3"); check("rp_rd3_val", {24'h0, out_seen}, 32'hA3);

        // Load and enable together: old MAR seen this cycle, new one next
        read_at(2, "le_pre");
        drive(1, 0, 0, 8'h00, 1, 1, 8'h05); cycle("le_both");
        check("le_old", {24'h0, out_seen}, 32'hA2);
        drive(1, 0, 0, 8'h00, 0, 1, 8'h00); cycle("le_next");
        check("le_new", {24'h0, out_seen}, 32'h05);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit pm;
            pm = ($urandom_range(0, 7) == 0) ? !bus_if.prog_mode : bus_if.prog_mode;
            drive(($urandom_range(0, 31) != 0), pm, 1'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning the width of the MAR and of the RAM address.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the width of a RAM word and of the bus.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-005 SHALL have port bus_in, input, DATA_W bits: shared bus value; bits [ADDR_W-1:0] carry the address.
REQ-006 SHALL have port mem_load, input, 1 bit: control-word bit 8; loads the MAR from the bus.
REQ-007 SHALL have port mem_en, input, 1 bit: control-word bit 7; drives RAM[MAR] onto out.
REQ-008 SHALL have port out, output, DATA_W bits: bus drive value; zero when not enabled.
REQ-009 SHALL have port mar, output, ADDR_W bits: current MAR contents (debug/observe).
REQ-010 SHALL have port prog_mode, input, 1 bit: request for program-load mode.
REQ-011 SHALL have port prog_valid, input, 1 bit: program byte valid.
REQ-012 SHALL have port prog_data, input, DATA_W bits: program byte.
REQ-013 SHALL have port prog_ready, output, 1 bit: unit accepts program bytes.
REQ-014 SHALL have port prog_count, output, ADDR_W+1 bits: bytes accepted since entering PROG, saturating at 2**ADDR_W.

Function
REQ-015 SHALL implement a 2**ADDR_W x DATA_W RAM, a MAR register, a write pointer wr_ptr (ADDR_W bits), and a two-state FSM {RUN, PROG}.
REQ-016 RUN->PROG SHALL occur on the edge where prog_mode=1; PROG->RUN on the edge where prog_mode=0.
REQ-017 On the RUN->PROG edge, wr_ptr and prog_count SHALL clear to 0; MAR SHALL be retained.
REQ-018 prog_ready SHALL equal (state==PROG), registered; it SHALL rise one cycle after prog_mode rises.
REQ-019 A write SHALL occur on each edge with prog_valid=1 and prog_ready=1: RAM[wr_ptr] <= prog_data, wr_ptr <= wr_ptr+1 (wrapping 15->0 at default), prog_count increments unless already 2**ADDR_W.
REQ-020 A write on the same edge as PROG->RUN SHALL still be accepted (ready was high that cycle).
REQ-021 prog_valid while prog_ready=0 SHALL be ignored, with no RAM write and no counter change.
REQ-022 In RUN, mem_load=1 SHALL set MAR <= bus_in[ADDR_W-1:0] at the edge; upper bus bits are ignored.
REQ-023 In RUN, out SHALL combinationally equal RAM[MAR] when mem_en=1, and 0 otherwise (zero read latency from MAR).
REQ-024 With mem_load and mem_en both high, out SHALL show the pre-edge MAR location; MAR updates at the edge.
REQ-025 In PROG, mem_load and mem_en SHALL be ignored: MAR held, out=0.
REQ-026 The RAM SHALL have no write path other than the PROG handshake.

Reset
REQ-027 With rst=0 at an edge: state=RUN, MAR=0, wr_ptr=0, prog_count=0, prog_ready=0; out=0 after that edge unless mem_en=1.
REQ-028 Reset SHALL NOT alter RAM contents.
REQ-029 Reset during PROG SHALL discard any write presented on that edge and return to RUN.
REQ-030 Reset SHALL take priority over prog_mode, mem_load, and any handshake on the same edge.

Verification
REQ-031 Reset, then prog_mode=1 with 3 back-to-back bytes 0x09, 0x1A, 0x2F (valid held), then prog_mode=0 -> RAM[0..2]=09, 1A, 2F; prog_count=3; prog_ready low one cycle after prog_mode falls.
REQ-032 In RUN, bus_in=0xF2 with mem_load=1, then mem_en=1 -> mar=2; out=0x2F; out=0 when mem_en=0.
REQ-033 Stream 17 bytes 0x00..0x10 in PROG -> prog_count=16 (saturated); RAM[0]=0x10 (wrap); RAM[1..15]=0x01..0x0F.
REQ-034 prog_valid pulsed while in RUN, and on the first cycle of prog_mode before ready -> no RAM change, prog_count unchanged.
REQ-035 rst=0 asserted mid-PROG with prog_valid=1, data 0xAA at wr_ptr=4 -> RAM[4] unchanged; state=RUN; MAR=0; prog_count=0; earlier bytes preserved.
REQ-036 mem_load=1 (bus 0x05) together with mem_en=1 while MAR=2 -> out=RAM[2] that cycle, RAM[5] the next cycle.
